morse_sequencer: RTL and testbench

Parametrised Morse playback engine, successor to the fixed 10-slot decomposer. Accepts a slot pattern of configurable width and length through a start/busy/done handshake, then plays it MSB-first at one slot per prescaler period. Drives tone and dot/dash flags for the audio/LED stage. Supports pause, a programmable slot duration and end-of-message signalling. Sits between the pattern register file and the audio/display outputs.

---
 rtl/morse_sequencer_pkg.sv | 10 +
 rtl/morse_sequencer_unit_prescaler.sv | 20 ++
 rtl/morse_sequencer.sv | 73 +++++++
 tb/tb_morse_sequencer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/morse_sequencer_pkg.sv
// morse_sequencer_pkg: shared state/slot encodings, default slot length and slot classifier.
package morse_sequencer_pkg;
    typedef enum logic {IDLE, PLAY} state_t;
    typedef enum logic [1:0] {SIL, DOT, DASH} slot_t;
    localparam int DIV_DEFAULT = 25000000;
    // Second half of a dash wins; otherwise a 1 followed by a 1 starts a dash.
    function automatic slot_t classify(input logic h, input logic n, input logic cont);
        return cont ? DASH : !h ? SIL : n ? DASH : DOT;
    endfunction
endpackage

// File: rtl/morse_sequencer_unit_prescaler.sv
// unit_prescaler: mod-DIV counter with a single-cycle tick on its last count.
module unit_prescaler
    import morse_sequencer_pkg::*;
#(
    parameter int DIV = DIV_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CW = $clog2(DIV);
    logic [CW-1:0] cnt;
    assign tick = en && cnt == CW'(DIV - 1);
    always_ff @(posedge clk) begin
        if (reset || clr) cnt <= '0;
        else if (en) cnt <= tick ? '0 : cnt + CW'(1);
    end
endmodule

// File: rtl/morse_sequencer.sv
// morse_sequencer: plays a W-slot Morse pattern MSB-first, one slot per DIV clocks,
// with pause, length clamp and a done pulse at end of message.
module morse_sequencer
    import morse_sequencer_pkg::*;
#(
    parameter int W   = 10,
    parameter int DIV = DIV_DEFAULT,
    parameter int LW  = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [W-1:0]  pattern,
    input  logic [LW-1:0] len,
    input  logic          pause,
    output logic          busy,
    output logic          done,
    output logic          tone,
    output logic          is_dot,
    output logic          is_dash,
    output logic [LW-1:0] slots_left
);
    state_t state, state_d;
    logic [W-1:0] sr, src;
    logic [LW-1:0] len_c, cnt;
    logic dash_first, tick, load, step, fin, cont, h, n;
    slot_t cls;

    unit_prescaler #(.DIV(DIV)) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .en   (state == PLAY && !pause),
        .clr  (state == IDLE),
        .tick (tick)
    );

    // Load and tick share one path: the new head comes from the pattern or the shifted register.
    always_comb begin
        len_c = len > LW'(W) ? LW'(W) : len;
        load = state == IDLE && start;
        step = state == PLAY && tick;
        src = load ? pattern : sr << 1;
        cnt = load ? len_c : slots_left - LW'(1);
        cont = !load && dash_first;
        fin = cnt == '0;
        h = src[W-1];
        n = cnt > LW'(1) && src[W-2];
        cls = classify(h, n, cont);
        state_d = (load || step) ? (fin ? IDLE : PLAY) : state;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            {sr, slots_left, dash_first, busy, done, tone, is_dot, is_dash} <= '0;
        end else begin
            done <= (load || step) && fin;
            if (load || step) begin
                sr <= src;
                slots_left <= cnt;
                dash_first <= !fin && !cont && h && n;
                busy <= !fin;
                tone <= !fin && cls != SIL;
                is_dot <= !fin && cls == DOT;
                is_dash <= !fin && cls == DASH;
            end
        end
    end
endmodule

// File: tb/tb_morse_sequencer.sv
// tb_morse_sequencer: directed cycle-by-cycle checks of playback, pause, reset and back-to-back starts.
module tb_morse_sequencer;
    logic clk = 0, reset = 1, start = 0, pause = 0;
    logic [9:0] pattern = '0;
    logic [3:0] len = '0;
    logic busy, done, tone, is_dot, is_dash;
    logic [3:0] slots_left;
    int vectors = 0, miscompares = 0;

    logic [9:0] tp_pat  [3] = '{10'b1101000000, 10'b1110000001, 10'b1011011000};
    logic [3:0] tp_len  [3] = '{4'd10, 4'd10, 4'd15};
    logic [3:0] tp_lc   [3] = '{4'd10, 4'd10, 4'd10};
    logic [9:0] tp_dash [3] = '{10'b1100000000, 10'b1100000000, 10'b0011011000};
    logic [9:0] tp_dot  [3] = '{10'b0001000000, 10'b0010000001, 10'b1000000000};

    morse_sequencer #(.W(10), .DIV(4)) dut (
        .clk(clk), .reset(reset), .start(start), .pattern(pattern), .len(len), .pause(pause),
        .busy(busy), .done(done), .tone(tone), .is_dot(is_dot), .is_dash(is_dash),
        .slots_left(slots_left)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [8:0] obs();
        return {busy, done, tone, is_dot, is_dash, slots_left};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1;
        next_cycle();
        vectors++;
        if (obs() !== 9'd0) begin
            miscompares++;
            $display("FAIL reset_hold: got %b expected %b", obs(), 9'd0);
        end
        reset = 0;
        next_cycle();
        vectors++;
        if (obs() !== 9'd0) begin
            miscompares++;
            $display("FAIL reset_idle: got %b expected %b", obs(), 9'd0);
        end
    endtask

    task automatic test_playback();
        logic [8:0] exp;
        int k, lc;
        for (int t = 0; t < 3; t++) begin
            pattern = tp_pat[t];
            len = tp_len[t];
            lc = int'(tp_lc[t]);
            start = 1;
            for (int c = 1; c <= lc * 4 + 2; c++) begin
                next_cycle();
                start = 0;
                k = (c - 1) / 4;
                if (c <= lc * 4)
                    exp = {1'b1, 1'b0, tp_dash[t][9-k] | tp_dot[t][9-k], tp_dot[t][9-k],
                           tp_dash[t][9-k], 4'(lc - k)};
                else if (c == lc * 4 + 1) exp = 9'b0_1_000_0000;
                else exp = 9'd0;
                vectors++;
                if (obs() !== exp) begin
                    miscompares++;
                    $display("FAIL playback%0d cycle %0d: got %b expected %b", t, c, obs(), exp);
                end
            end
        end
    endtask

    task automatic test_len_zero();
        logic [8:0] exp;
        pattern = 10'b1111111111;
        len = 0;
        start = 1;
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            start = 0;
            exp = c == 1 ? 9'b0_1_000_0000 : 9'd0;
            vectors++;
            if (obs() !== exp) begin
                miscompares++;
                $display("FAIL len_zero cycle %0d: got %b expected %b", c, obs(), exp);
            end
        end
    endtask

    task automatic test_pause();
        logic [8:0] exp;
        pattern = 10'b1000000000;
        len = 3;
        start = 1;
        for (int c = 1; c <= 19; c++) begin
            next_cycle();
            exp = c <= 9  ? 9'b1_0_110_0011 :
                  c <= 13 ? 9'b1_0_000_0010 :
                  c <= 17 ? 9'b1_0_000_0001 :
                  c == 18 ? 9'b0_1_000_0000 : 9'd0;
            vectors++;
            if (obs() !== exp) begin
                miscompares++;
                $display("FAIL pause cycle %0d: got %b expected %b", c, obs(), exp);
            end
            pause = c >= 2 && c <= 6;
            start = c == 5;
            if (c == 5) begin
                pattern = 10'b1111111111;
                len = 10;
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [8:0] exp;
        pattern = 10'b1101000000;
        len = 10;
        start = 1;
        for (int c = 1; c <= 22; c++) begin
            next_cycle();
            start = 0;
            reset = 0;
            exp = c <= 4  ? 9'b1_0_101_1010 :
                  c <= 8  ? 9'b1_0_101_1001 :
                  c <= 10 ? 9'b1_0_000_1000 :
                  c <= 12 ? 9'd0 :
                  c <= 16 ? 9'b1_0_000_0010 :
                  c <= 20 ? 9'b1_0_110_0001 :
                  c == 21 ? 9'b0_1_000_0000 : 9'd0;
            vectors++;
            if (obs() !== exp) begin
                miscompares++;
                $display("FAIL reset_mid cycle %0d: got %b expected %b", c, obs(), exp);
            end
            if (c == 10) reset = 1;
            if (c == 12) begin
                start = 1;
                pattern = 10'b0110000000;
                len = 2;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp;
        int p;
        pattern = 10'b1100000000;
        len = 2;
        start = 1;
        for (int c = 1; c <= 19; c++) begin
            next_cycle();
            p = c <= 9 ? c : c - 9;
            exp = c == 19 ? 9'd0 :
                  p <= 4  ? 9'b1_0_101_0010 :
                  p <= 8  ? 9'b1_0_101_0001 : 9'b0_1_000_0000;
            vectors++;
            if (obs() !== exp) begin
                miscompares++;
                $display("FAIL back_to_back cycle %0d: got %b expected %b", c, obs(), exp);
            end
            if (c == 18) start = 0;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_playback();
        test_len_zero();
        test_pause();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
